// File: rtl/b_vpe_slave_tm.sv
// Time-multiplexed VPE slave: local clause store and assignment register, scanned
// LANES clauses per cycle to yield satisfy/unsat-count/polarity-sum and an optional update.

module b_vpe_slave_tm_lane #(
  parameter int N_VAR = 60,
  parameter int VW    = 6
) (
  input  logic             act_i,
  input  logic             idx_ok_i,
  input  logic [VW-1:0]    idx_i,
  input  logic [N_VAR-1:0] pos_i,
  input  logic [N_VAR-1:0] neg_i,
  input  logic [N_VAR-1:0] var_i,
  output logic             unsat_o,
  output logic             pos_hit_o,
  output logic             neg_hit_o
);
  // empty clause and padding lanes both come out satisfied
  assign unsat_o   = act_i & (pos_i != '0 || neg_i != '0) &
                     ~((|(pos_i & var_i)) | (|(neg_i & ~var_i)));
  assign pos_hit_o = act_i & idx_ok_i & pos_i[idx_i];
  assign neg_hit_o = act_i & idx_ok_i & neg_i[idx_i];
endmodule

module b_vpe_slave_tm #(
  parameter int N_VAR    = 60,
  parameter int N_CLAUSE = 32,
  parameter int LANES    = 8,
  parameter int AW       = $clog2(N_CLAUSE),
  parameter int VW       = $clog2(N_VAR),
  parameter int CW       = $clog2(N_CLAUSE + 1),
  parameter int SW       = $clog2(N_CLAUSE + 1) + 1,
  parameter bit TIE_KEEP = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [N_VAR-1:0]     wr_pos_i,
  input  logic [N_VAR-1:0]     wr_neg_i,
  input  logic                 var_ld_i,
  input  logic [N_VAR-1:0]     var_in_i,
  input  logic                 start_i,
  input  logic                 op_i,
  input  logic [VW-1:0]        var_idx_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 satisfy_o,
  output logic [CW-1:0]        unsat_cnt_o,
  output logic signed [SW-1:0] sum_out_o,
  output logic [N_VAR-1:0]     var_out_o,
  output logic                 vi_flip_o
);
  localparam int G  = (N_CLAUSE + LANES - 1) / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = $clog2(G * LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [N_VAR-1:0]     pos_q [N_CLAUSE];
  logic [N_VAR-1:0]     neg_q [N_CLAUSE];
  logic [N_VAR-1:0]     var_q, scan_var_q;
  logic                 op_q;
  logic [VW-1:0]        idx_q;
  logic [GW-1:0]        g_q;
  logic [CW-1:0]        cnt_q, cnt_d, unsat_q;
  logic signed [SW-1:0] sum_q, sum_d, sum_out_q;
  logic                 satisfy_q, flip_q;
  // a write landing on the START edge is parked so the scan sees the old store
  logic                 pend_q;
  logic [AW-1:0]        pend_addr_q;
  logic [N_VAR-1:0]     pend_pos_q, pend_neg_q;

  logic [LANES-1:0]     lane_unsat, lane_pos, lane_neg;
  logic [CW-1:0]        grp_unsat;
  logic signed [SW-1:0] grp_sum;
  logic                 idx_ok, last, wr_ok, go, old_v, new_v;

  assign idx_ok = int'(idx_q) < N_VAR;
  assign last   = (g_q == GW'(G - 1));
  assign wr_ok  = wr_en_i && (int'(wr_addr_i) < N_CLAUSE);
  assign go     = (state_q == S_IDLE) && start_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0]    cidx;
    logic             act;
    logic [N_VAR-1:0] lpos, lneg;
    assign cidx = IW'(g_q) * IW'(LANES) + IW'(l);
    assign act  = (cidx < IW'(N_CLAUSE));
    assign lpos = act ? pos_q[cidx[AW-1:0]] : '0;
    assign lneg = act ? neg_q[cidx[AW-1:0]] : '0;
    b_vpe_slave_tm_lane #(.N_VAR(N_VAR), .VW(VW)) u_lane (
      .act_i(act), .idx_ok_i(idx_ok), .idx_i(idx_q),
      .pos_i(lpos), .neg_i(lneg), .var_i(scan_var_q),
      .unsat_o(lane_unsat[l]), .pos_hit_o(lane_pos[l]), .neg_hit_o(lane_neg[l])
    );
  end

  always_comb begin
    grp_unsat = '0;
    grp_sum   = '0;
    for (int l = 0; l < LANES; l++) begin
      grp_unsat = grp_unsat + CW'(lane_unsat[l]);
      grp_sum   = grp_sum + SW'(lane_pos[l]) - SW'(lane_neg[l]);
    end
  end

  assign cnt_d = cnt_q + grp_unsat;
  assign sum_d = sum_q + grp_sum;
  assign old_v = idx_ok ? var_q[idx_q] : 1'b0;

  always_comb begin
    new_v = old_v;
    if (sum_d > 0)      new_v = 1'b1;
    else if (sum_d < 0) new_v = 1'b0;
    else if (!TIE_KEEP) new_v = ~old_v;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SCAN;
      S_SCAN:  if (last)    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < N_CLAUSE; c++) begin
        pos_q[c] <= '0;
        neg_q[c] <= '0;
      end
      var_q <= '0;  scan_var_q <= '0;
      op_q <= 1'b0; idx_q <= '0;  g_q <= '0;
      cnt_q <= '0;  sum_q <= '0;
      unsat_q <= '0; sum_out_q <= '0; satisfy_q <= 1'b0; flip_q <= 1'b0;
      pend_q <= 1'b0; pend_addr_q <= '0; pend_pos_q <= '0; pend_neg_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_ok && go) begin
            pend_q      <= 1'b1;
            pend_addr_q <= wr_addr_i;
            pend_pos_q  <= wr_pos_i;
            pend_neg_q  <= wr_neg_i;
          end else if (wr_ok) begin
            pos_q[wr_addr_i] <= wr_pos_i;
            neg_q[wr_addr_i] <= wr_neg_i;
          end
          if (var_ld_i) var_q <= var_in_i;
          if (go) begin
            op_q       <= op_i;
            idx_q      <= var_idx_i;
            scan_var_q <= var_q;
            g_q        <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
          end
        end
        S_SCAN: begin
          cnt_q <= cnt_d;
          sum_q <= sum_d;
          g_q   <= g_q + GW'(1);
          if (last) begin
            unsat_q   <= cnt_d;
            satisfy_q <= (cnt_d == '0);
            sum_out_q <= sum_d;
            flip_q    <= op_q && idx_ok && (new_v != old_v);
            if (op_q && idx_ok) var_q[idx_q] <= new_v;
          end
        end
        S_DONE: begin
          if (pend_q) begin
            pos_q[pend_addr_q] <= pend_pos_q;
            neg_q[pend_addr_q] <= pend_neg_q;
            pend_q             <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign satisfy_o   = satisfy_q;
  assign unsat_cnt_o = unsat_q;
  assign sum_out_o   = sum_out_q;
  assign var_out_o   = var_q;
  assign vi_flip_o   = flip_q;
endmodule
